// File: rtl/mux_scan_nx1.sv
// Registered N:1 multiplexer with an automatic channel-scan sequencer.
// Manual mode passes sel through; scan mode walks the enabled mask bits with a fixed dwell.
module mux_scan_nx1 #(
    parameter int N_IN  = 32,
    parameter int SEL_W = $clog2(N_IN),
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  in,
    input  logic [SEL_W-1:0] sel,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    input  logic [N_IN-1:0]  mask,
    output logic             out,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int NP = 1 << SEL_W;
    localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t            state;
    logic [DCNT_W-1:0] dcnt;

    // Padding to the full select range lets an out-of-range sel read a zero.
    logic [NP-1:0]    in_pad;
    logic [NP-1:0]    legal;
    logic [SEL_W-1:0] first_ch;
    logic [SEL_W-1:0] next_ch;
    logic             wrap;
    logic             mask_any;

    assign in_pad   = NP'(in);
    assign legal    = NP'({N_IN{1'b1}});
    assign mask_any = |mask;

    // While scanning, out_sel is the current channel, so the search is relative to it.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        wrap     = 1'b1;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_ch = SEL_W'(i);
            end
            if (mask[i] && (i > int'(out_sel))) begin
                next_ch = SEL_W'(i);
                wrap    = 1'b0;
            end
        end
        if (wrap) begin
            next_ch = first_ch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dcnt       <= '0;
            out        <= 1'b0;
            out_sel    <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mode && start && !stop && mask_any) begin
                        state     <= S_SCAN;
                        dcnt      <= '0;
                        out_sel   <= first_ch;
                        out       <= in_pad[first_ch];
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        dcnt      <= '0;
                        out_sel   <= sel;
                        out       <= in_pad[sel];
                        out_valid <= legal[sel];
                        busy      <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (stop || !mode || ((dcnt == DCNT_LAST) && !mask_any)) begin
                        state     <= S_IDLE;
                        dcnt      <= '0;
                        out_sel   <= sel;
                        out       <= in_pad[sel];
                        out_valid <= legal[sel];
                        busy      <= 1'b0;
                    end else if (dcnt == DCNT_LAST) begin
                        dcnt       <= '0;
                        out_sel    <= next_ch;
                        out        <= in_pad[next_ch];
                        frame_done <= wrap;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                        out  <= in_pad[out_sel];
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Self-checking bench for mux_scan_nx1: three instances (32/dwell 4, 32/dwell 2, 24/dwell 3)
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_mux_scan_nx1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_v = '0;
    logic [4:0]  sel_v = '0;
    logic        mode_v = 1'b0;
    logic        start_v = 1'b0;
    logic        stop_v = 1'b0;
    logic [31:0] mask_v = '0;

    logic       d_out[3];
    logic [4:0] d_sel[3];
    logic       d_ov[3];
    logic       d_fd[3];
    logic       d_busy[3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_scan_nx1 #(.N_IN(32), .DWELL(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in(in_v), .sel(sel_v), .mode(mode_v),
        .start(start_v), .stop(stop_v), .mask(mask_v),
        .out(d_out[0]), .out_sel(d_sel[0]), .out_valid(d_ov[0]),
        .frame_done(d_fd[0]), .busy(d_busy[0])
    );

    mux_scan_nx1 #(.N_IN(32), .DWELL(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in(in_v), .sel(sel_v), .mode(mode_v),
        .start(start_v), .stop(stop_v), .mask(mask_v),
        .out(d_out[1]), .out_sel(d_sel[1]), .out_valid(d_ov[1]),
        .frame_done(d_fd[1]), .busy(d_busy[1])
    );

    mux_scan_nx1 #(.N_IN(24), .DWELL(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .in(in_v[23:0]), .sel(sel_v), .mode(mode_v),
        .start(start_v), .stop(stop_v), .mask(mask_v[23:0]),
        .out(d_out[2]), .out_sel(d_sel[2]), .out_valid(d_ov[2]),
        .frame_done(d_fd[2]), .busy(d_busy[2])
    );

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int n_of(int k);
        return (k == 2) ? 24 : 32;
    endfunction

    function automatic int dwell_of(int k);
        case (k)
            0:       return 4;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int lowest_set(logic [31:0] m, int n);
        for (int i = 0; i < n; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int next_above(logic [31:0] m, int n, int ch);
        for (int i = ch + 1; i < n; i++) if (m[i]) return i;
        return -1;
    endfunction

    bit   m_scan[3];
    int   m_cnt[3];
    int   m_sel[3];
    logic m_out[3];
    logic m_ov[3];
    logic m_fd[3];
    logic m_busy[3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_scan[k] = 0; m_cnt[k] = 0; m_sel[k] = 0;
            m_out[k] = 0; m_ov[k] = 0; m_fd[k] = 0; m_busy[k] = 0;
        end
    endtask

    task automatic model_edge(int k);
        int  n = n_of(k);
        int  dw = dwell_of(k);
        int  lo = lowest_set(mask_v, n);
        int  nx;
        bit  manual = 0;
        m_fd[k] = 0;
        if (!m_scan[k]) begin
            if (mode_v && start_v && !stop_v && lo >= 0) begin
                m_scan[k] = 1; m_cnt[k] = 0; m_sel[k] = lo;
                m_out[k] = in_v[lo]; m_ov[k] = 1; m_busy[k] = 1;
            end else manual = 1;
        end else if (stop_v || !mode_v) begin
            manual = 1;
        end else if (m_cnt[k] == dw - 1) begin
            if (lo < 0) manual = 1;
            else begin
                nx = next_above(mask_v, n, m_sel[k]);
                if (nx < 0) begin
                    nx = lo;
                    m_fd[k] = 1;
                end
                m_sel[k] = nx; m_cnt[k] = 0; m_out[k] = in_v[nx];
            end
        end else begin
            m_cnt[k]++;
            m_out[k] = in_v[m_sel[k]];
        end
        if (manual) begin
            m_scan[k] = 0; m_cnt[k] = 0; m_sel[k] = int'(sel_v); m_busy[k] = 0;
            if (int'(sel_v) < n) begin
                m_out[k] = in_v[sel_v]; m_ov[k] = 1;
            end else begin
                m_out[k] = 0; m_ov[k] = 0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else for (int k = 0; k < 3; k++) model_edge(k);
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check("cmp_out", k, d_out[k], m_out[k]);
            check("cmp_out_sel", k, d_sel[k], 32'(m_sel[k]));
            check("cmp_out_valid", k, d_ov[k], m_ov[k]);
            check("cmp_frame_done", k, d_fd[k], m_fd[k]);
            check("cmp_busy", k, d_busy[k], m_busy[k]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int exp_sel[5];
        int exp_out[5];
        exp_sel = '{0, 0, 31, 31, 0};
        exp_out = '{0, 0, 1, 1, 0};

        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_out", k, d_out[k], 0);
            check("rst_out_sel", k, d_sel[k], 0);
            check("rst_out_valid", k, d_ov[k], 0);
            check("rst_busy", k, d_busy[k], 0);
        end
        tick();
        rst_n = 1'b1;

        // Manual sweep: alternating pattern, out tracks sel one cycle later.
        in_v = 32'h5555_5555;
        mode_v = 1'b0;
        for (int s = 0; s < 32; s++) begin
            sel_v = 5'(s);
            tick();
            check("sweep_out", 0, d_out[0], (s % 2 == 0) ? 1 : 0);
            check("sweep_valid", 0, d_ov[0], 1);
            check("sweep_busy", 0, d_busy[0], 0);
        end

        // Full scan with every channel enabled.
        mask_v = 32'hFFFF_FFFF;
        mode_v = 1'b1;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        for (int c = 0; c < 128; c++) begin
            check("full_sel", 0, d_sel[0], c / 4);
            check("full_fd", 0, d_fd[0], 0);
            tick();
        end
        check("full_wrap_sel", 0, d_sel[0], 0);
        check("full_wrap_fd", 0, d_fd[0], 1);
        tick();
        check("full_fd_width", 0, d_fd[0], 0);
        mode_v = 1'b0;
        tick();

        // Stop while sitting on channel 5 mid-dwell.
        mode_v = 1'b1;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        repeat (21) tick();
        check("stop_pre_sel", 0, d_sel[0], 5);
        check("stop_pre_busy", 0, d_busy[0], 1);
        stop_v = 1'b1;
        sel_v = 5'd9;
        tick();
        check("stop_busy", 0, d_busy[0], 0);
        check("stop_sel", 0, d_sel[0], 9);
        stop_v = 1'b0;
        mode_v = 1'b0;
        tick();

        // Start with an empty mask is ignored.
        mask_v = '0;
        mode_v = 1'b1;
        start_v = 1'b1;
        sel_v = 5'd2;
        tick();
        check("empty_busy", 0, d_busy[0], 0);
        check("empty_fd", 0, d_fd[0], 0);
        check("empty_sel", 0, d_sel[0], 2);
        start_v = 1'b0;

        // Clearing the mask mid-dwell lets the dwell finish, then drops to idle.
        mask_v = 32'hFFFF_FFFF;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        tick();
        mask_v = '0;
        tick();
        check("clr_busy_c2", 0, d_busy[0], 1);
        check("clr_sel_c2", 0, d_sel[0], 0);
        tick();
        check("clr_busy_c3", 0, d_busy[0], 1);
        tick();
        check("clr_busy_c4", 0, d_busy[0], 0);
        check("clr_sel_c4", 0, d_sel[0], 2);
        mode_v = 1'b0;
        tick();

        // Sparse mask on the dwell-2 instance.
        in_v = 32'h8000_0000;
        mask_v = 32'h8000_0001;
        mode_v = 1'b1;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("sparse_sel", 1, d_sel[1], exp_sel[c]);
            check("sparse_out", 1, d_out[1], exp_out[c]);
            check("sparse_fd", 1, d_fd[1], (c == 4) ? 1 : 0);
            tick();
        end
        mode_v = 1'b0;
        tick();

        // Asynchronous reset while on channel 7.
        in_v = 32'hFFFF_FFFF;
        mask_v = 32'hFFFF_FFFF;
        mode_v = 1'b1;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        repeat (29) tick();
        check("rst_mid_pre_sel", 0, d_sel[0], 7);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_mid_out", k, d_out[k], 0);
            check("rst_mid_sel", k, d_sel[k], 0);
            check("rst_mid_valid", k, d_ov[k], 0);
            check("rst_mid_fd", k, d_fd[k], 0);
            check("rst_mid_busy", k, d_busy[k], 0);
        end
        tick();
        rst_n = 1'b1;
        sel_v = 5'd4;
        tick();
        check("rst_after_busy", 0, d_busy[0], 0);
        check("rst_after_sel", 0, d_sel[0], 4);
        mode_v = 1'b0;

        // Out-of-range select on the 24-channel instance.
        in_v = 32'h0080_0000;
        sel_v = 5'd30;
        tick();
        check("oor_out", 2, d_out[2], 0);
        check("oor_valid", 2, d_ov[2], 0);
        check("oor_wide_valid", 0, d_ov[0], 1);
        sel_v = 5'd23;
        tick();
        check("top_out", 2, d_out[2], 1);
        check("top_valid", 2, d_ov[2], 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
